// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with IF/ID output register and delay-slot redirects
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              resetn,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_inst,
    input  logic              jbr_taken,
    input  logic [31:0]       jbr_target,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_inst,
    output logic [31:0]       fetch_cnt
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc;
    logic [31:0] pc_nx;
    logic [31:0] pend_target;
    logic [31:0] jbr_aligned;
    logic [31:0] pc_inc;
    logic        advance;
    logic        xfer;
    logic        capture;
    logic        pend_load;

    assign advance     = !if_valid || id_ready;
    assign xfer        = if_valid && id_ready;
    assign jbr_aligned = jbr_target & 32'hFFFF_FFFC;
    assign pc_inc      = pc + 32'd4;
    assign rom_addr    = pc[ADDR_W+1:2];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= BOOT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            BOOT:    state_nx = RUN;
            RUN:     if (!advance && jbr_taken) state_nx = HOLD;
            HOLD:    if (advance) state_nx = RUN;
            default: state_nx = BOOT;
        endcase
    end

    // The word captured alongside a redirect is the delay slot, so capture never depends on jbr_taken.
    always_comb begin
        capture   = 1'b0;
        pend_load = 1'b0;
        pc_nx     = pc;
        case (state)
            RUN: begin
                if (advance) begin
                    capture = 1'b1;
                    pc_nx   = jbr_taken ? jbr_aligned : pc_inc;
                end else if (jbr_taken) begin
                    pend_load = 1'b1;
                end
            end
            HOLD: begin
                if (advance) begin
                    capture = 1'b1;
                    pc_nx   = jbr_taken ? jbr_aligned : pend_target;
                end else if (jbr_taken) begin
                    pend_load = 1'b1;
                end
            end
            default: begin
                capture   = 1'b0;
                pend_load = 1'b0;
                pc_nx     = pc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc          <= RESET_PC & 32'hFFFF_FFFC;
            pend_target <= 32'd0;
            if_valid    <= 1'b0;
            if_pc       <= 32'd0;
            if_inst     <= 32'd0;
            fetch_cnt   <= 32'd0;
        end else begin
            pc <= pc_nx;
            if (pend_load) begin
                pend_target <= jbr_aligned;
            end
            if (capture) begin
                if_valid <= 1'b1;
                if_pc    <= pc;
                if_inst  <= rom_inst;
            end
            if (xfer) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed scoreboard bench for inst_fetch
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        resetn;
    logic [9:0]  rom_addr;
    logic [31:0] rom_inst;
    logic        jbr_taken;
    logic [31:0] jbr_target;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] fetch_cnt;

    logic        resetn_w;
    logic [9:0]  w_rom_addr;
    logic [31:0] w_rom_inst;
    logic        w_ready;
    logic        w_if_valid;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_inst;
    logic [31:0] w_fetch_cnt;

    logic [31:0] rom [0:1023];
    logic [31:0] sb [$];
    int          passed = 0;
    int          total = 0;
    int          exp_cnt = 0;

    always #5 clk = ~clk;

    assign rom_inst   = rom[rom_addr];
    assign w_rom_inst = rom[w_rom_addr];

    inst_fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(10)) dut (
        .clk(clk), .resetn(resetn), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .jbr_taken(jbr_taken), .jbr_target(jbr_target), .id_ready(id_ready),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .fetch_cnt(fetch_cnt)
    );

    inst_fetch #(.RESET_PC(32'h0000_0FFC), .ADDR_W(10)) dut_wrap (
        .clk(clk), .resetn(resetn_w), .rom_addr(w_rom_addr), .rom_inst(w_rom_inst),
        .jbr_taken(1'b0), .jbr_target(32'h0), .id_ready(w_ready),
        .if_valid(w_if_valid), .if_pc(w_if_pc), .if_inst(w_if_inst), .fetch_cnt(w_fetch_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input logic [31:0] pc);
        sb.push_back(pc);
    endtask

    // A handshake completes at the coming edge when valid and ready are both high now.
    task automatic cycle();
        logic [31:0] e;
        if (if_valid === 1'b1 && id_ready === 1'b1) begin
            total++;
            assert (sb.size() != 0) begin
                passed++;
                e = sb.pop_front();
                exp_cnt++;
                chk("xfer_pc", if_pc, e);
                chk("xfer_inst", if_inst, rom[e[11:2]]);
            end else $error("FAIL sb_underflow: observed unexpected pc %h expected none", if_pc);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            rom[i] = 32'h1000_0000 + (i * 32'h0001_0101);
        end
        rom[0]  = 32'h2401_0001;
        rom[1]  = 32'h0001_1100;
        rom[25] = 32'ha07a_0005;

        resetn = 1'b0; resetn_w = 1'b0;
        id_ready = 1'b1; w_ready = 1'b1;
        jbr_taken = 1'b0; jbr_target = 32'h0;
        cycle(); cycle();
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_inst", if_inst, 32'd0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        chk("rst_addr", {22'd0, rom_addr}, 32'd0);

        // sequential fetch
        resetn = 1'b1;
        cycle();
        chk("boot_valid", {31'd0, if_valid}, 32'd0);
        push(32'h0); push(32'h4);
        cycle();
        chk("first_valid", {31'd0, if_valid}, 32'd1);
        chk("first_inst", if_inst, 32'h2401_0001);
        cycle(); cycle();
        chk("seq_cnt", fetch_cnt, exp_cnt);

        // backpressure
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_pc", if_pc, 32'h8);
            chk("bp_inst", if_inst, rom[2]);
            chk("bp_addr", {22'd0, rom_addr}, 32'd3);
            chk("bp_cnt", fetch_cnt, 32'd2);
        end
        id_ready = 1'b1;
        push(32'h8); push(32'hc); push(32'h10);
        cycle(); cycle();

        // redirect on advance, low target bits ignored
        jbr_taken = 1'b1; jbr_target = 32'h66;
        push(32'h14); push(32'h64);
        cycle();
        jbr_taken = 1'b0;
        cycle();
        chk("redir_inst", if_inst, 32'ha07a_0005);

        // redirect during stall
        jbr_taken = 1'b1; jbr_target = 32'h2c;
        push(32'h68);
        cycle();
        jbr_taken = 1'b0;
        cycle();
        id_ready = 1'b0; jbr_taken = 1'b1; jbr_target = 32'h0;
        cycle();
        jbr_taken = 1'b0;
        cycle();
        chk("stall_pc", if_pc, 32'h2c);
        chk("stall_addr", {22'd0, rom_addr}, 32'd12);
        id_ready = 1'b1;
        push(32'h2c); push(32'h30); push(32'h0);
        cycle(); cycle();
        id_ready = 1'b0; jbr_taken = 1'b1; jbr_target = 32'h20;
        cycle();
        jbr_target = 32'h8;
        cycle();
        jbr_taken = 1'b0; id_ready = 1'b1;
        push(32'h4); push(32'h8); push(32'hc);
        cycle(); cycle(); cycle();
        chk("latest_wins_pc", if_pc, 32'hc);

        // reset while holding a redirect
        jbr_taken = 1'b1; jbr_target = 32'h40;
        cycle();
        id_ready = 1'b0; jbr_target = 32'h80;
        cycle();
        jbr_taken = 1'b0;
        chk("hold_addr", {22'd0, rom_addr}, 32'h10);
        chk("hold_cnt", fetch_cnt, exp_cnt);
        resetn = 1'b0;
        cycle();
        exp_cnt = 0;
        chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        chk("mid_rst_cnt", fetch_cnt, 32'd0);
        chk("mid_rst_addr", {22'd0, rom_addr}, 32'd0);
        resetn = 1'b1; id_ready = 1'b1;
        push(32'h0); push(32'h4);
        cycle();
        chk("mid_boot_valid", {31'd0, if_valid}, 32'd0);
        cycle();
        chk("post_rst_pc", if_pc, 32'h0);
        cycle(); cycle();
        id_ready = 1'b0;
        chk("post_rst_cnt", fetch_cnt, exp_cnt);
        chk("sb_empty", sb.size(), 32'd0);

        // address wrap
        resetn_w = 1'b1;
        cycle();
        chk("wrap_boot_addr", {22'd0, w_rom_addr}, 32'h3ff);
        chk("wrap_boot_valid", {31'd0, w_if_valid}, 32'd0);
        cycle();
        chk("wrap_pc0", w_if_pc, 32'hffc);
        chk("wrap_inst0", w_if_inst, rom[1023]);
        chk("wrap_addr0", {22'd0, w_rom_addr}, 32'h000);
        cycle();
        chk("wrap_pc1", w_if_pc, 32'h1000);
        chk("wrap_inst1", w_if_inst, 32'h2401_0001);
        chk("wrap_cnt1", w_fetch_cnt, 32'd1);
        w_ready = 1'b0;
        cycle(); cycle();
        chk("wrap_stall_cnt", w_fetch_cnt, 32'd1);
        chk("wrap_stall_pc", w_if_pc, 32'h1000);
        w_ready = 1'b1;
        cycle();
        chk("wrap_cnt2", w_fetch_cnt, 32'd2);
        chk("wrap_pc2", w_if_pc, 32'h1004);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
